// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iq_pkg
//  Purpose  : Shared sizes and the default-width entry layout for the
//             16-entry out-of-order issue queue.
//  Revision : 1.0  initial release
// ============================================================================
package iq_pkg;

  localparam int IQ_ENTRIES = 16;
  localparam int IQ_IDX_W   = 4;
  localparam int IQ_DATA_W  = 32;
  localparam int IQ_TAG_W   = 6;

  // One queue slot at the default payload/tag widths.
  typedef struct packed {
    logic                 valid;
    logic [IQ_DATA_W-1:0] data;
    logic [IQ_TAG_W-1:0]  dest;
    logic [IQ_TAG_W-1:0]  src1;
    logic                 rdy1;
    logic [IQ_TAG_W-1:0]  src2;
    logic                 rdy2;
  } iq_entry_t;

endpackage
`default_nettype wire

// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_if
//  Purpose  : Dispatch, wakeup, grant and issue signals of the issue queue.
//             The slave modport is the queue itself; master is its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface issue_queue_if
  import iq_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int TAG_W  = IQ_TAG_W
) ();

  logic                  Flush_IN;
  logic                  Dispatch_Valid_IN;
  logic [DATA_W-1:0]     Dispatch_Data_IN;
  logic [TAG_W-1:0]      Dispatch_Dest_IN;
  logic [TAG_W-1:0]      Dispatch_Src1_IN;
  logic [TAG_W-1:0]      Dispatch_Src2_IN;
  logic                  Dispatch_Rdy1_IN;
  logic                  Dispatch_Rdy2_IN;
  logic [1:0]            Wakeup_Valid_IN;
  logic [2*TAG_W-1:0]    Wakeup_Tag_IN;
  logic                  Issue_IN;
  logic [IQ_IDX_W-1:0]   grant_index_IN;
  logic [IQ_ENTRIES-1:0] request_OUT;
  logic                  Full_OUT;
  logic [4:0]            Count_OUT;
  logic                  Issued_Valid_OUT;
  logic [DATA_W-1:0]     Issued_Data_OUT;
  logic [TAG_W-1:0]      Issued_Dest_OUT;

  modport master (
    output Flush_IN, Dispatch_Valid_IN, Dispatch_Data_IN, Dispatch_Dest_IN,
           Dispatch_Src1_IN, Dispatch_Src2_IN, Dispatch_Rdy1_IN, Dispatch_Rdy2_IN,
           Wakeup_Valid_IN, Wakeup_Tag_IN, Issue_IN, grant_index_IN,
    input  request_OUT, Full_OUT, Count_OUT, Issued_Valid_OUT, Issued_Data_OUT,
           Issued_Dest_OUT
  );

  modport slave (
    input  Flush_IN, Dispatch_Valid_IN, Dispatch_Data_IN, Dispatch_Dest_IN,
           Dispatch_Src1_IN, Dispatch_Src2_IN, Dispatch_Rdy1_IN, Dispatch_Rdy2_IN,
           Wakeup_Valid_IN, Wakeup_Tag_IN, Issue_IN, grant_index_IN,
    output request_OUT, Full_OUT, Count_OUT, Issued_Valid_OUT, Issued_Data_OUT,
           Issued_Dest_OUT
  );

endinterface
`default_nettype wire

// File: rtl/iq_free_select.sv
`default_nettype none
// ============================================================================
//  Module   : iq_free_select
//  Purpose  : Lowest-index priority encoder over the free (not valid) slots.
//  Revision : 1.0  initial release
// ============================================================================
module iq_free_select
  import iq_pkg::*;
(
  input  logic [IQ_ENTRIES-1:0] valid,
  output logic [IQ_IDX_W-1:0]   alloc_idx,
  output logic                  alloc_ok
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    alloc_idx = '0;
    alloc_ok  = 1'b0;
    for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_idx = IQ_IDX_W'(i);
        alloc_ok  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue
//  Purpose  : 16-entry out-of-order issue queue. Tracks source readiness via
//             the two-lane wakeup bus, requests ready entries from the select
//             logic and reads the granted entry out to register read.
//  Revision : 1.0  initial release
// ============================================================================
module issue_queue
  import iq_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int TAG_W  = IQ_TAG_W
) (
  input  logic        CLK,
  input  logic        RESET_N,
  issue_queue_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  src1;
    logic              rdy1;
    logic [TAG_W-1:0]  src2;
    logic              rdy2;
  } entry_t;

  logic [IQ_ENTRIES-1:0] valid;
  entry_t                entries [IQ_ENTRIES];
  logic [4:0]            count;
  logic                  issued_valid;
  logic [DATA_W-1:0]     issued_data;
  logic [TAG_W-1:0]      issued_dest;

  logic [IQ_ENTRIES-1:0] request;
  logic [IQ_IDX_W-1:0]   alloc_idx;
  logic                  alloc_ok;
  logic                  full;
  logic                  dispatch_ok;
  logic                  issue_ok;
  logic                  dsp_rdy1;
  logic                  dsp_rdy2;

  // True when any asserted wakeup lane carries this tag.
  function automatic logic woken(input logic [TAG_W-1:0]   tag,
                                 input logic [1:0]         lane_vld,
                                 input logic [2*TAG_W-1:0] lane_tag);
    return (lane_vld[0] && (lane_tag[TAG_W-1:0] == tag)) ||
           (lane_vld[1] && (lane_tag[2*TAG_W-1:TAG_W] == tag));
  endfunction

  generate
    for (genvar i = 0; i < IQ_ENTRIES; i++) begin : g_req
      assign request[i] = valid[i] & entries[i].rdy1 & entries[i].rdy2;
    end
  endgenerate

  iq_free_select u_free_select (
    .valid     (valid),
    .alloc_idx (alloc_idx),
    .alloc_ok  (alloc_ok)
  );

  // Full is taken from pre-edge state, so a slot freed by this edge's issue
  // is not reused until the next edge.
  assign full        = &valid;
  assign dispatch_ok = bus.Dispatch_Valid_IN & ~full & alloc_ok;
  assign issue_ok    = bus.Issue_IN & request[bus.grant_index_IN];
  assign dsp_rdy1    = bus.Dispatch_Rdy1_IN |
                       woken(bus.Dispatch_Src1_IN, bus.Wakeup_Valid_IN, bus.Wakeup_Tag_IN);
  assign dsp_rdy2    = bus.Dispatch_Rdy2_IN |
                       woken(bus.Dispatch_Src2_IN, bus.Wakeup_Valid_IN, bus.Wakeup_Tag_IN);

  // Control state: valid bits, occupancy counter and the issue output register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid        <= '0;
      count        <= '0;
      issued_valid <= 1'b0;
      issued_data  <= '0;
      issued_dest  <= '0;
    end else if (bus.Flush_IN) begin
      valid        <= '0;
      count        <= '0;
      issued_valid <= 1'b0;
    end else begin
      issued_valid <= issue_ok;
      if (issue_ok) begin
        issued_data            <= entries[bus.grant_index_IN].data;
        issued_dest            <= entries[bus.grant_index_IN].dest;
        valid[bus.grant_index_IN] <= 1'b0;
      end
      // The allocated slot is always free, so it never collides with the grant.
      if (dispatch_ok) begin
        valid[alloc_idx] <= 1'b1;
      end
      count <= count + 5'(dispatch_ok) - 5'(issue_ok);
    end
  end

  // Entry payload and readiness; meaningful only while the slot is valid.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (dispatch_ok && !bus.Flush_IN && (alloc_idx == IQ_IDX_W'(i))) begin
        entries[i] <= '{data: bus.Dispatch_Data_IN, dest: bus.Dispatch_Dest_IN,
                        src1: bus.Dispatch_Src1_IN, rdy1: dsp_rdy1,
                        src2: bus.Dispatch_Src2_IN, rdy2: dsp_rdy2};
      end else if (valid[i]) begin
        if (woken(entries[i].src1, bus.Wakeup_Valid_IN, bus.Wakeup_Tag_IN)) begin
          entries[i].rdy1 <= 1'b1;
        end
        if (woken(entries[i].src2, bus.Wakeup_Valid_IN, bus.Wakeup_Tag_IN)) begin
          entries[i].rdy2 <= 1'b1;
        end
      end
    end
  end

  assign bus.request_OUT      = request;
  assign bus.Full_OUT         = full;
  assign bus.Count_OUT        = count;
  assign bus.Issued_Valid_OUT = issued_valid;
  assign bus.Issued_Data_OUT  = issued_data;
  assign bus.Issued_Dest_OUT  = issued_dest;

endmodule
`default_nettype wire

// File: doc/issue_queue.md
# issue_queue

16-entry out-of-order issue queue that produces the request vector for `Wakeup_Select` and consumes its issue/grant-index response. Renamed instructions enter from dispatch. Each entry tracks readiness of two source tags and updates that readiness from the result-tag wakeup bus. When `Wakeup_Select` grants an entry, the queue reads that entry out to the register-read stage and frees it.

## Interface
Parameters:
- `DATA_W`, 32: opaque instruction payload width.
- `TAG_W`, 6: physical register tag width.
- Entry count is fixed at 16, matching the 16-bit request/grant interface.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `Flush_IN` in 1: synchronous; invalidates all entries.
- `Dispatch_Valid_IN` in 1: dispatch request.
- `Dispatch_Data_IN` in `DATA_W`: instruction payload.
- `Dispatch_Dest_IN` in `TAG_W`: destination tag, carried with the payload.
- `Dispatch_Src1_IN`, `Dispatch_Src2_IN` in `TAG_W`: source tags.
- `Dispatch_Rdy1_IN`, `Dispatch_Rdy2_IN` in 1: source ready at dispatch.
- `Wakeup_Valid_IN` in 2: per-lane wakeup valid.
- `Wakeup_Tag_IN` in 2×`TAG_W`: lane 0 is bits [`TAG_W`-1:0]; lane 1 is the upper bits.
- `Issue_IN` in 1: `Issue_OUT` from `Wakeup_Select`.
- `grant_index_IN` in 4: `grant_index_OUT` from `Wakeup_Select`.
- `request_OUT` out 16: ready-to-issue vector to `Wakeup_Select`.
- `Full_OUT` out 1: all 16 entries valid.
- `Count_OUT` out 5: number of valid entries, 0..16.
- `Issued_Valid_OUT` out 1: issued instruction present.
- `Issued_Data_OUT` out `DATA_W`: payload of the issued instruction.
- `Issued_Dest_OUT` out `TAG_W`: destination tag of the issued instruction.

## Operation
- **Entry state:** `valid`, `data`, `dest`, `src1`, `rdy1`, `src2`, `rdy2`.
- **Request vector:** `request_OUT[i] = valid[i] & rdy1[i] & rdy2[i]`.
  - Combinational from registered state only; no input-to-request path.
  - `Wakeup_Select` closes the loop combinationally in the same cycle.
- **Dispatch:**
  - Accepted on an edge where `Dispatch_Valid_IN=1` and `Full_OUT=0`.
  - Writes the lowest-index entry whose `valid=0`.
  - Dispatch while full is dropped silently; dispatch logic must honour `Full_OUT`.
- **Wakeup:**
  - On each edge, every valid entry compares `src1` and `src2` against every lane with `Wakeup_Valid_IN` set; a match sets the corresponding `rdy`.
  - `rdy` bits never clear while an entry is valid.
- **Dispatch bypass:** a dispatched source whose tag matches a same-cycle wakeup lane is written with `rdy=1`, regardless of the `Dispatch_Rdy` input.
- **Issue:**
  - When `Issue_IN=1` and `request_OUT[grant_index_IN]=1`, the entry is copied to the `Issued_*` registers and its `valid` clears on that edge.
  - A grant to a non-requesting entry is ignored and `Issued_Valid_OUT=0`.
- **Simultaneous dispatch and issue:**
  - Both happen on the same edge.
  - `Full_OUT` reflects pre-edge state, so a full queue refuses dispatch even while issuing.
  - The freed slot is not reused on that edge.
- **Flush:**
  - Clears all `valid` bits and `Issued_Valid_OUT`.
  - Overrides dispatch, wakeup and issue on the same edge.
- **Count:** `Count_OUT` is a registered counter.
  - +1 on accepted dispatch.
  - −1 on valid issue.
  - Net 0 when both happen.
  - Set to 0 on flush or reset.
  - Must always equal the popcount of `valid`.

## Timing
- **Reset values:** all `valid`=0, `Count_OUT`=0, `Full_OUT`=0, `request_OUT`=0, `Issued_Valid_OUT`=0, `Issued_Data_OUT`=0, `Issued_Dest_OUT`=0.
- **Reset mid-operation:** queue contents are discarded immediately; no partial issue completes.
- **Dispatch-to-request:** dispatch at edge N with both sources ready → `request_OUT` bit high in cycle N+1.
- **Wakeup-to-request:** wakeup at edge N → request high in cycle N+1.
- **Grant-to-output:** grant sampled at edge N → `Issued_*` valid in cycle N+1 for exactly one cycle, unless another issue follows.
- **Request drop after grant:** the granted entry's request bit is low in cycle N+1, so there is no double issue.
- **Throughput:** one issue per cycle, one dispatch per cycle.

## Structure
- Shared package `iq_pkg` holds:
  - `IQ_ENTRIES=16` and `IQ_IDX_W=4`.
  - The entry struct/typedef (`iq_entry_t`).
  - Default `TAG_W` and `DATA_W`.
- Sub-module `iq_free_select`: a 16-bit lowest-index priority encoder over `~valid`, producing `alloc_idx[3:0]` and `alloc_ok`. It is the same priority style as `Wakeup_Select`, but over free slots.
- Tag comparators are inline: 16 entries × 2 sources × 2 lanes.

## Test plan
1. Reset then dispatch `data=0xA5`, `dest=7`, `rdy1=rdy2=1` → entry 0 valid; `request_OUT=16'h0001` next cycle. Grant index 0 → `Issued_Data_OUT=0xA5`, `Issued_Dest_OUT=7`, `request_OUT=0`, `Count_OUT=0`.
2. Dispatch with `src1=12` not ready, then wake tag 12 on lane 1 → `request_OUT` bit rises one cycle after the wakeup edge. A wakeup with tag 13 → no change.
3. Dispatch `src2=20` not ready in the same cycle as a lane-0 wakeup of tag 20 → request asserted the next cycle (bypass).
4. Dispatch 16 entries → `Full_OUT=1`, `Count_OUT=16`. A 17th dispatch together with a grant of entry 5 → 17th dropped, `Count_OUT=15`. A following dispatch lands in entry 5.
5. `Issue_IN=1`, `grant_index_IN=3`, entry 3 not requesting → no state change, `Issued_Valid_OUT=0`.
6. With 10 entries valid, assert `Flush_IN` together with a dispatch and a grant → `Count_OUT=0`, `request_OUT=0`, `Issued_Valid_OUT=0`. Assert `RESET_N` low mid-stream → all outputs reach reset values immediately, without waiting for a clock edge.
